// File: rtl/tail_branch_metric_seq_if.sv
// Tail LLR load bus: valid/ready handshake carrying one (systematic, parity) pair per beat.
interface tail_branch_metric_seq_if #(
  parameter int unsigned W = 16
);
  logic                tail_valid;
  logic                tail_ready;
  logic signed [W-1:0] tail_sys;
  logic signed [W-1:0] tail_par;

  modport master (output tail_valid, output tail_sys, output tail_par, input tail_ready);
  modport slave  (input tail_valid, input tail_sys, input tail_par, output tail_ready);
endinterface

// File: rtl/tail_branch_metric_seq.sv
// Buffers the tail LLR pairs of one constituent encoder and replays their branch metrics in
// reverse order to the backward termination stage. METRIC_SAT_EN selects saturating metrics.
module tail_branch_metric_seq #(
  parameter int unsigned W        = 16,
  parameter int unsigned TAIL_LEN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  tail_branch_metric_seq_if.slave tail,
  output logic                    state1,
  output logic signed [W-1:0]     m00,
  output logic signed [W-1:0]     m01,
  output logic signed [W-1:0]     m10,
  output logic signed [W-1:0]     m11,
  output logic                    step_valid,
  output logic [1:0]              step_idx,
  output logic                    done
);

  localparam int unsigned IdxW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam int unsigned CntW = $clog2(TAIL_LEN + 1);
  localparam int unsigned MW   = W + 2;

  typedef enum logic [1:0] {StIdle, StInit, StRun, StFin} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                tail_ready_q;
  logic [2*W-1:0]      buf_q [TAIL_LEN];

  logic [IdxW-1:0]     rd_idx;
  logic signed [W-1:0] rd_sys, rd_par;
  logic signed [MW-1:0] s_ext, p_ext, sum_a, dif_b, neg_a, neg_b;
  logic signed [W-1:0] m00_d, m01_d, m10_d, m11_d;

  assign tail.tail_ready = tail_ready_q;

  function automatic logic signed [W-1:0] reduce(input logic signed [MW-1:0] v);
`ifdef METRIC_SAT_EN
    logic signed [MW-1:0] max_v, min_v;
    max_v = MW'((1 << (W - 1)) - 1);
    min_v = -max_v - 1;
    if (v > max_v)      return max_v[W-1:0];
    else if (v < min_v) return min_v[W-1:0];
    else                return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  // Metrics for the step about to be presented: top entry on leaving INIT, else k-1.
  always_comb begin
    rd_idx = (state_q == StInit) ? IdxW'(TAIL_LEN - 1) : IdxW'(step_idx - 2'd1);
    {rd_sys, rd_par} = buf_q[rd_idx];
    s_ext = MW'(rd_sys);
    p_ext = MW'(rd_par);
    sum_a = s_ext + p_ext;
    dif_b = s_ext - p_ext;
    neg_a = -sum_a;
    neg_b = -dif_b;
    m00_d = reduce(sum_a >>> 1);
    m11_d = reduce(neg_a >>> 1);
    m01_d = reduce(dif_b >>> 1);
    m10_d = reduce(neg_b >>> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tail_ready_q <= 1'b1;
      state1       <= 1'b1;
      m00          <= '0;
      m01          <= '0;
      m10          <= '0;
      m11          <= '0;
      step_valid   <= 1'b0;
      step_idx     <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tail.tail_valid && tail_ready_q) begin
            buf_q[cnt_q[IdxW-1:0]] <= {tail.tail_sys, tail.tail_par};
            cnt_q                  <= cnt_q + 1'b1;
            if (cnt_q == CntW'(TAIL_LEN - 1)) begin
              state_q      <= StInit;
              tail_ready_q <= 1'b0;
              state1       <= 1'b1;
            end
          end
        end
        StInit: begin
          state_q    <= StRun;
          state1     <= 1'b0;
          step_valid <= 1'b1;
          step_idx   <= 2'(TAIL_LEN - 1);
          m00        <= m00_d;
          m01        <= m01_d;
          m10        <= m10_d;
          m11        <= m11_d;
        end
        StRun: begin
          if (step_idx != 2'd0) begin
            step_idx <= step_idx - 2'd1;
            m00      <= m00_d;
            m01      <= m01_d;
            m10      <= m10_d;
            m11      <= m11_d;
          end else begin
            state_q    <= StFin;
            step_valid <= 1'b0;
            done       <= 1'b1;
            m00        <= '0;
            m01        <= '0;
            m10        <= '0;
            m11        <= '0;
          end
        end
        StFin: begin
          state_q      <= StIdle;
          cnt_q        <= '0;
          tail_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
